// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code receiver
//
// Contents:
//   PS2_EXT / PS2_BRK  prefix bytes folded into key events
//   ps2_state_e        deframer states
//   ps2_event_t        {ext, brk, code[7:0]} key event, 10 bits
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - show-ahead synchronous event FIFO with level output
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   s_tvalid/s_tdata  write side; no backpressure, a write while full is dropped
//   m_tvalid/m_tready read side handshake; m_tdata always shows the head entry
//   m_tdata           head entry, holds the last popped value while empty
//   level             number of stored entries
//   drop              one-cycle pulse when a write is discarded
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_tvalid,
  input  logic [WIDTH-1:0]             s_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [WIDTH-1:0]             m_tdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] last_q;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full     = (level_q == LW'(DEPTH));
  assign m_tvalid = (level_q != '0);
  assign pop      = m_tvalid & m_tready;
  // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
  assign wr_en    = s_tvalid & (~full | pop);
  assign drop     = s_tvalid & full & ~pop;
  assign level    = level_q;
  // While empty the head slot is stale; present the last delivered entry instead.
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      last_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard receiver with prefix folding and event FIFO
//
// Ports:
//   clk, rst                  system clock, asynchronous active-low reset
//   ps2_clk, ps2_data         raw PS/2 lines, asynchronous to clk
//   ev_valid/ev_ready         event handshake; ev_ext/ev_brk/ev_code carry the head event
//   fifo_level                events currently buffered
//   busy                      a frame is being received
//   clear_err                 clears the sticky flags below
//   parity_err, frame_err,
//   overflow                  sticky error flags
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic                            ev_ext,
  output logic                            ev_brk,
  output logic [7:0]                      ev_code,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            busy,
  input  logic                            clear_err,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_MAX = TCW'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Input path: bit 0 is the clock line, bit 1 the data line.
  // ---------------------------------------------------------------------------
  logic [1:0]          raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          filt;
  logic [1:0][FCW-1:0] fcnt;
  logic                filt_clk_d;
  logic                fall;
  logic                din;

  assign raw = {ps2_data, ps2_clk};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      fcnt       <= '0;
      filt_clk_d <= 1'b1;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        // The filtered level only follows after FILTER_LEN consecutive
        // cycles of disagreement; any agreement restarts the count.
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  assign fall = filt_clk_d & ~filt[0];
  assign din  = filt[1];

  // ---------------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------------
  ps2_state_e     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TCW-1:0] tcnt;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           bad_frame;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      bad_frame  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      bad_frame  <= 1'b0;
      // Clear first so that an error detected in the same cycle overrides it.
      if (clear_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end

      if (state == IDLE) begin
        if (fall) begin
          if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
            tcnt    <= TCW'(1);
          end else begin
            frame_err <= 1'b1;
            bad_frame <= 1'b1;
          end
        end
      end else if (fall) begin
        // tcnt counts cycles elapsed since the most recent falling edge.
        tcnt <= TCW'(1);
        case (state)
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= din;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!din) begin
              frame_err <= 1'b1;
            end
            if (!(^{shreg, par_bit})) begin
              parity_err <= 1'b1;
            end
            if (din && (^{shreg, par_bit})) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              bad_frame <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == T_MAX) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        bad_frame <= 1'b1;
      end else begin
        tcnt <= tcnt + TCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  logic       ext_pend;
  logic       brk_pend;
  logic       push;
  logic       drop;
  ps2_event_t push_ev;
  ps2_event_t head_ev;

  assign push    = byte_valid && (byte_data != PS2_EXT) && (byte_data != PS2_BRK);
  assign push_ev = {ext_pend, brk_pend, byte_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (bad_frame) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (push),
    .s_tdata  (push_ev),
    .m_tvalid (ev_valid),
    .m_tready (ev_ready),
    .m_tdata  (head_ev),
    .level    (fifo_level),
    .drop     (drop)
  );

  assign ev_ext  = head_ev.ext;
  assign ev_brk  = head_ev.brk;
  assign ev_code = head_ev.code;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;

  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, busy, parity_err, frame_err, overflow;
  logic [7:0] ev_code;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: expected FIFO contents, pend flags, sticky flags.
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  bit         m_ext, m_brk, m_perr, m_ferr, m_ovf;

  ps2_scan_receiver #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ext     (ev_ext),
    .ev_brk     (ev_brk),
    .ev_code    (ev_code),
    .fifo_level (fifo_level),
    .busy       (busy),
    .clear_err  (clear_err),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int i, input bit bad_par);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return (~^b) ^ bad_par;
    return 1'b1;
  endfunction

  task automatic send_bit(input bit b, input int glitch_len);
    ps2_data = b;
    if (glitch_len > 0) begin
      wait_cycles(5);
      ps2_clk = 1'b0;
      wait_cycles(glitch_len);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 5 - glitch_len);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_at);
    for (int i = 0; i < 11; i++) send_bit(frame_bit(b, i, bad_par), (i == glitch_at) ? FL - 1 : 0);
    wait_cycles(2 * HALF);
    if (bad_par) begin
      m_perr = 1'b1;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else begin
      model_byte(b);
    end
  endtask

  // Consumer: accepts every presented event until the FIFO runs dry.
  task automatic drain();
    got_q.delete();
    ev_ready = 1'b1;
    for (int c = 0; c < 16 && ev_valid; c++) begin
      got_q.push_back({ev_ext, ev_brk, ev_code});
      wait_cycles(1);
    end
    ev_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_cycles(3);
    n_checks++; if ({ev_valid, ev_ext, ev_brk, ev_code, fifo_level, busy} !== 15'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected all zero", {ev_valid, ev_ext, ev_brk, ev_code, fifo_level, busy}); end
    rst = 1'b1;
    wait_cycles(2 * HALF);
    n_checks++; if ({parity_err, frame_err, overflow, ev_valid, busy} !== 5'd0) begin n_fail++; $display("FAIL reset_idle: got %b expected 00000", {parity_err, frame_err, overflow, ev_valid, busy}); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 10; i++) send_bit(frame_bit(8'h1C, i, 1'b0), 0);
    ps2_data = 1'b1;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    // raw edge -> fall takes 2+FL cycles, event visible two cycles after fall
    wait_cycles(FL + 3);
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got ev_valid=%b expected 0", ev_valid); end
    wait_cycles(1);
    n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got ev_valid=%b expected 1", ev_valid); end
    n_checks++; if ({ev_ext, ev_brk, ev_code, fifo_level} !== {2'b00, 8'h1C, 3'd1}) begin n_fail++; $display("FAIL basic_event: got %b_%h lvl %0d expected 00_1c lvl 1", {ev_ext, ev_brk}, ev_code, fifo_level); end
    n_checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b expected 000", {parity_err, frame_err, overflow}); end
    wait_cycles(HALF - FL - 4);
    ps2_clk = 1'b1;
    wait_cycles(2 * HALF);
    model_byte(8'h1C);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_prefix();
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL prefix_level: got %0d expected 2", fifo_level); end
    drain();
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL prefix_count: got %0d expected 2", got_q.size()); end
    n_checks++; if (got_q.size() > 0 && got_q[0] !== {2'b01, 8'h1C}) begin n_fail++; $display("FAIL prefix_brk: got %h expected %h", got_q[0], {2'b01, 8'h1C}); end
    n_checks++; if (got_q.size() > 1 && got_q[1] !== {2'b11, 8'h75}) begin n_fail++; $display("FAIL prefix_ext_brk: got %h expected %h", got_q[1], {2'b11, 8'h75}); end
    exp_q.delete();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, -1);
    n_checks++; if ({parity_err, frame_err, ev_valid} !== {m_perr, m_ferr, 1'b0}) begin n_fail++; $display("FAIL parity_flag: got %b expected %b", {parity_err, frame_err, ev_valid}, {m_perr, m_ferr, 1'b0}); end
    send_frame(8'h1C, 1'b0, -1);
    drain();
    n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL parity_recover: got %0d events expected 1 of %h", got_q.size(), exp_q[0]); end
    exp_q.delete();
    pulse_clear();
    n_checks++; if (parity_err !== m_perr) begin n_fail++; $display("FAIL parity_clear: got %b expected %b", parity_err, m_perr); end
  endtask

  task automatic test_glitch();
    send_frame(8'h1C, 1'b0, 4);
    send_frame(8'h5A, 1'b0, 9);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_event%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags: got %b expected 00", {parity_err, frame_err}); end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    foreach (codes[i]) send_frame(codes[i], 1'b0, -1);
    n_checks++; if (fifo_level !== 3'(exp_q.size())) begin n_fail++; $display("FAIL ovf_level: got %0d expected %0d", fifo_level, exp_q.size()); end
    n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", overflow, m_ovf); end
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_order%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if ({ev_valid, fifo_level} !== 4'd0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0000", {ev_valid, fifo_level}); end
    exp_q.delete();
    pulse_clear();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_timeout();
    send_frame(8'hE0, 1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(frame_bit(8'h6B, i, 1'b0), 0);
    ps2_data = frame_bit(8'h6B, 4, 1'b0);
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    // last fall lands 2+FL cycles after the raw edge, error TO+1 cycles later
    wait_cycles(FL + TO + 2 - HALF);
    n_checks++; if ({frame_err, busy} !== 2'b01) begin n_fail++; $display("FAIL timeout_early: got err,busy=%b expected 01", {frame_err, busy}); end
    wait_cycles(1);
    m_ferr = 1'b1;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    n_checks++; if ({frame_err, busy} !== {m_ferr, 1'b0}) begin n_fail++; $display("FAIL timeout_edge: got err,busy=%b expected %b", {frame_err, busy}, {m_ferr, 1'b0}); end
    pulse_clear();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", frame_err); end
    send_frame(8'h6B, 1'b0, -1);
    drain();
    n_checks++; if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h6B}) begin n_fail++; $display("FAIL timeout_ext_cleared: got %0d events first %h expected 1 of %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0, {2'b00, 8'h6B}); end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0:       b = 8'hE0;
          1:       b = 8'hF0;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_frame(b, 1'b0, -1);
      end
      n_checks++; if (fifo_level !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rand_level%0d: got %0d expected %0d", g, fifo_level, exp_q.size()); end
      drain();
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count%0d: got %0d expected %0d", g, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_event%0d_%0d: got %h expected %h", g, i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
    end
    n_checks++; if ({parity_err, frame_err, overflow} !== {m_perr, m_ferr, m_ovf}) begin n_fail++; $display("FAIL rand_flags: got %b expected %b", {parity_err, frame_err, overflow}, {m_perr, m_ferr, m_ovf}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_bit(frame_bit(8'h33, i, 1'b0), 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got %b expected 1", busy); end
    rst = 1'b0;
    #2;
    n_checks++; if ({ev_valid, ev_ext, ev_brk, ev_code, fifo_level, busy, parity_err, frame_err, overflow} !== 18'd0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected all zero", {ev_valid, ev_ext, ev_brk, ev_code, fifo_level, busy, parity_err, frame_err, overflow}); end
    wait_cycles(3);
    rst = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    wait_cycles(4 * HALF);
    n_checks++; if ({ev_valid, busy, parity_err, frame_err, overflow} !== 5'd0) begin n_fail++; $display("FAIL midreset_after: got %b expected 00000", {ev_valid, busy, parity_err, frame_err, overflow}); end
    send_frame(8'h29, 1'b0, -1);
    drain();
    n_checks++; if (got_q.size() != 1 || got_q[0] !== {2'b00, 8'h29}) begin n_fail++; $display("FAIL midreset_recover: got %0d events expected 1 of %h", got_q.size(), {2'b00, 8'h29}); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_glitch();
    test_overflow();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
